// File: rtl/decode_pkg.sv
// Shared decode constants: RV32I opcodes/funct fields, ALU and memory command encodings,
// plus the immediate generator used by the ID/EX stage.
package decode_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BRA   = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1110;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b11;

  // alt picks SUB for the add slot and SRA for the shift-right slot.
  function automatic logic [3:0] alu_base(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] inst);
    logic [31:0] imm;
    case (inst[6:0])
      OP_LUI, OP_AUIPC: imm = {inst[31:12], 12'b0};
      OP_JAL:   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_JALR, OP_LOAD: imm = {{20{inst[31]}}, inst[31:20]};
      // funct3 001/101 are the shifts: zero-extended shamt, inst[30] stays out.
      OP_ALUI:  imm = (inst[13:12] == 2'b01) ? {27'b0, inst[24:20]}
                                             : {{20{inst[31]}}, inst[31:20]};
      OP_STORE: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRA:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      default:  imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_p_if.sv
// Handshake and datapath bundle between IF/ID, register file, writeback and the ID/EX stage.
interface decode_stage_p_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_WB = 2
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_inst;
  logic [XLEN-1:0]          in_pc;
  logic [4:0]               rs1_idx;
  logic [4:0]               rs2_idx;
  logic [XLEN-1:0]          rf_rdata1;
  logic [XLEN-1:0]          rf_rdata2;
  logic [NUM_WB-1:0]        wb_en;
  logic [5*NUM_WB-1:0]      wb_rd;
  logic [XLEN*NUM_WB-1:0]   wb_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_inst;
  logic [XLEN-1:0]          out_pc;
  logic [XLEN-1:0]          out_rs1_val;
  logic [XLEN-1:0]          out_rs2_val;
  logic [XLEN-1:0]          out_imm;
  logic [4:0]               out_rd;
  logic                     out_rd_we;
  logic [3:0]               out_alu_op;
  logic [1:0]               out_mem_cmd;
  logic                     out_illegal;
  logic                     out_muldiv;

  modport master (
    output flush, in_valid, in_inst, in_pc, rf_rdata1, rf_rdata2, wb_en, wb_rd, wb_data,
           out_ready,
    input  in_ready, rs1_idx, rs2_idx, out_valid, out_inst, out_pc, out_rs1_val, out_rs2_val,
           out_imm, out_rd, out_rd_we, out_alu_op, out_mem_cmd, out_illegal, out_muldiv
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, rf_rdata1, rf_rdata2, wb_en, wb_rd, wb_data,
           out_ready,
    output in_ready, rs1_idx, rs2_idx, out_valid, out_inst, out_pc, out_rs1_val, out_rs2_val,
           out_imm, out_rd, out_rd_we, out_alu_op, out_mem_cmd, out_illegal, out_muldiv
  );
endinterface

// File: rtl/decode_fwd_mux.sv
// One operand's writeback forwarding: lowest-index matching port wins, x0 always reads zero.
module decode_fwd_mux #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_WB = 2
) (
  input  logic [4:0]              idx_i,
  input  logic [XLEN-1:0]         rf_rdata_i,
  input  logic [NUM_WB-1:0]       wb_en_i,
  input  logic [5*NUM_WB-1:0]     wb_rd_i,
  input  logic [XLEN*NUM_WB-1:0]  wb_data_i,
  output logic [XLEN-1:0]         val_o
);
  logic found;

  always_comb begin
    val_o = rf_rdata_i;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_WB; i++) begin
      if (!found && wb_en_i[i] && (wb_rd_i[5*i +: 5] == idx_i)) begin
        val_o = wb_data_i[XLEN*i +: XLEN];
        found = 1'b1;
      end
    end
    if (idx_i == 5'd0) val_o = '0;
  end
endmodule

// File: rtl/decode_stage_p.sv
// RV32I ID/EX stage with valid/ready handshake, writeback forwarding and load-use bubbling.
// Define DECODE_MEXT_EN to decode M-extension ops instead of flagging them illegal.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_WB = 2
) (
  input  logic            clk,
  input  logic            rst,
  decode_stage_p_if.slave bus
);
  logic [31:0] inst;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  assign inst        = bus.in_inst;
  assign opcode      = inst[6:0];
  assign funct3      = inst[14:12];
  assign funct7      = inst[31:25];
  assign rd          = inst[11:7];
  assign bus.rs1_idx = inst[19:15];
  assign bus.rs2_idx = inst[24:20];

  logic [XLEN-1:0] rs1_val, rs2_val;

  decode_fwd_mux #(.XLEN(XLEN), .NUM_WB(NUM_WB)) u_fwd_rs1 (
    .idx_i(inst[19:15]), .rf_rdata_i(bus.rf_rdata1), .wb_en_i(bus.wb_en),
    .wb_rd_i(bus.wb_rd), .wb_data_i(bus.wb_data), .val_o(rs1_val)
  );
  decode_fwd_mux #(.XLEN(XLEN), .NUM_WB(NUM_WB)) u_fwd_rs2 (
    .idx_i(inst[24:20]), .rf_rdata_i(bus.rf_rdata2), .wb_en_i(bus.wb_en),
    .wb_rd_i(bus.wb_rd), .wb_data_i(bus.wb_data), .val_o(rs2_val)
  );

  logic [3:0] alu_op;
  logic [1:0] mem_cmd;
  logic       rd_we, illegal, muldiv, use_rs1, use_rs2;

  always_comb begin
    alu_op  = ALU_ADD;
    mem_cmd = MEM_NONE;
    rd_we   = 1'b0;
    illegal = 1'b0;
    muldiv  = 1'b0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        use_rs1 = 1'b0;
        rd_we   = 1'b1;
      end
      OP_JALR: begin
        rd_we   = 1'b1;
        illegal = (funct3 != 3'b000);
      end
      OP_BRA: begin
        use_rs2 = 1'b1;
        illegal = (funct3[2:1] == 2'b01);
        alu_op  = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
      end
      OP_LOAD: begin
        mem_cmd = MEM_LOAD;
        rd_we   = 1'b1;
        illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        use_rs2 = 1'b1;
        mem_cmd = MEM_STORE;
        illegal = funct3[2] || (funct3 == 3'b011);
      end
      OP_ALUI: begin
        rd_we   = 1'b1;
        alu_op  = alu_base(funct3, (funct3 == F3_SR) && inst[30]);
        illegal = ((funct3 == F3_SLL) && (funct7 != F7_BASE)) ||
                  ((funct3 == F3_SR) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
      end
      OP_ALU: begin
        use_rs2 = 1'b1;
        rd_we   = 1'b1;
        if (funct7 == F7_BASE) begin
          alu_op = alu_base(funct3, 1'b0);
        end else if ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))) begin
          alu_op = alu_base(funct3, 1'b1);
`ifdef DECODE_MEXT_EN
        end else if (funct7 == F7_MULDIV) begin
          muldiv = 1'b1;
          alu_op = {1'b0, funct3};
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    // Illegal ops still flow to EX for trapping but must have no side effects.
    if (illegal) begin
      alu_op  = ALU_ADD;
      mem_cmd = MEM_NONE;
      rd_we   = 1'b0;
      muldiv  = 1'b0;
    end
    if (rd == 5'd0) rd_we = 1'b0;
  end

  logic            rdy_q;
  logic            valid_q, valid_d, rd_we_q, rd_we_d, illegal_q, illegal_d, muldiv_q, muldiv_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [4:0]      rd_q, rd_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [1:0]      mem_cmd_q, mem_cmd_d;
  logic            adv, haz;

  assign adv = !valid_q || bus.out_ready;
  assign haz = valid_q && (mem_cmd_q == MEM_LOAD) && (rd_q != 5'd0) && bus.in_valid &&
               ((use_rs1 && (inst[19:15] == rd_q)) || (use_rs2 && (inst[24:20] == rd_q)));
  // rdy_q keeps the stage closed until the first edge after reset release.
  assign bus.in_ready = rdy_q && (bus.flush || (adv && !haz));

  always_comb begin
    valid_d   = valid_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    alu_op_d  = alu_op_q;
    mem_cmd_d = mem_cmd_q;
    illegal_d = illegal_q;
    muldiv_d  = muldiv_q;
    if (rdy_q) begin
      if (bus.flush) begin
        valid_d = 1'b0;
        rd_we_d = 1'b0;
      end else if (adv && haz) begin
        valid_d = 1'b0;
      end else if (adv) begin
        valid_d   = bus.in_valid;
        inst_d    = inst;
        pc_d      = bus.in_pc;
        rs1_d     = rs1_val;
        rs2_d     = rs2_val;
        imm_d     = XLEN'($signed(imm_gen(inst)));
        rd_d      = rd;
        rd_we_d   = rd_we;
        alu_op_d  = alu_op;
        mem_cmd_d = mem_cmd;
        illegal_d = illegal;
        muldiv_d  = muldiv;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q     <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      alu_op_q  <= '0;
      mem_cmd_q <= '0;
      illegal_q <= 1'b0;
      muldiv_q  <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      alu_op_q  <= alu_op_d;
      mem_cmd_q <= mem_cmd_d;
      illegal_q <= illegal_d;
      muldiv_q  <= muldiv_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_inst    = inst_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_rs1_val = rs1_q;
  assign bus.out_rs2_val = rs2_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rd_we   = rd_we_q;
  assign bus.out_alu_op  = alu_op_q;
  assign bus.out_mem_cmd = mem_cmd_q;
  assign bus.out_illegal = illegal_q;
  assign bus.out_muldiv  = muldiv_q;
endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: directed cases with literal expectations, then random traffic
// compared every cycle against a behavioural model of the stage.
module tb_decode_stage_p;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NUM_WB = 2;
`ifdef DECODE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_stage_p_if #(.XLEN(XLEN), .NUM_WB(NUM_WB)) bus ();
  decode_stage_p #(.XLEN(XLEN), .NUM_WB(NUM_WB)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] rf [32];
  assign bus.rf_rdata1 = rf[bus.rs1_idx];
  assign bus.rf_rdata2 = rf[bus.rs2_idx];

  typedef struct {
    logic [31:0] inst, pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic        we, ill, md;
    logic [3:0]  alu;
    logic [1:0]  mem;
  } ex_t;

  ex_t  m;
  logic m_v, m_rdy, last_acc;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    for (int i = 0; i < NUM_WB; i++)
      if (bus.wb_en[i] && bus.wb_rd[5*i +: 5] == idx) return bus.wb_data[32*i +: 32];
    return rf[idx];
  endfunction

  function automatic ex_t decode_model(input logic [31:0] inst, input logic [31:0] pc);
    ex_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [31:0] sx, i_imm;
    logic [3:0] tab [8];
    tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h5, 4'h7};
    op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    sx = {32{inst[31]}};
    i_imm = (sx << 11) | 32'(inst[30:20]);
    e.inst = inst; e.pc = pc; e.rd = inst[11:7];
    e.rs1 = fwd(inst[19:15]); e.rs2 = fwd(inst[24:20]);
    e.imm = 0; e.alu = 0; e.mem = 0; e.we = 0; e.ill = 0; e.md = 0;
    case (op)
      7'h37, 7'h17: begin e.imm = inst & 32'hFFFFF000; e.we = 1; end
      7'h6f: begin
        e.imm = (sx << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) |
                (32'(inst[30:21]) << 1);
        e.we = 1;
      end
      7'h67: begin e.imm = i_imm; e.we = 1; e.ill = (f3 != 0); end
      7'h63: begin
        e.imm = (sx << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) |
                (32'(inst[11:8]) << 1);
        e.ill = (f3 == 2 || f3 == 3);
        e.alu = (f3 < 4) ? 4'h8 : (f3 < 6) ? 4'h2 : 4'h3;
      end
      7'h03: begin e.imm = i_imm; e.mem = 1; e.we = 1; e.ill = !(f3 inside {0, 1, 2, 4, 5}); end
      7'h23: begin
        e.imm = (sx << 11) | (32'(inst[30:25]) << 5) | 32'(inst[11:7]);
        e.mem = 3; e.ill = (f3 > 2);
      end
      7'h13: begin
        e.we = 1;
        if (f3 == 1 || f3 == 5) begin
          e.imm = 32'(inst[24:20]);
          e.alu = (f3 == 5 && inst[30]) ? 4'hE : tab[f3];
          e.ill = (f3 == 1) ? (f7 != 0) : !(f7 == 0 || f7 == 7'h20);
        end else begin
          e.imm = i_imm; e.alu = tab[f3];
        end
      end
      7'h33: begin
        e.we = 1;
        if (f7 == 0) e.alu = tab[f3];
        else if (f7 == 7'h20 && f3 == 0) e.alu = 4'h8;
        else if (f7 == 7'h20 && f3 == 5) e.alu = 4'hE;
        else if (f7 == 7'h01 && MEXT) begin e.md = 1; e.alu = {1'b0, f3}; end
        else e.ill = 1;
      end
      default: e.ill = 1;
    endcase
    if (e.ill) begin e.we = 0; e.mem = 0; e.alu = 0; e.md = 0; end
    if (e.rd == 0) e.we = 0;
    return e;
  endfunction

  function automatic logic exp_haz();
    logic [6:0] op;
    logic u1, u2;
    op = bus.in_inst[6:0];
    u1 = !(op inside {7'h37, 7'h17, 7'h6f});
    u2 = op inside {7'h33, 7'h23, 7'h63};
    return m_v && m.mem == 2'b01 && m.rd != 0 && bus.in_valid &&
           ((u1 && bus.in_inst[19:15] == m.rd) || (u2 && bus.in_inst[24:20] == m.rd));
  endfunction

  function automatic logic exp_in_ready();
    if (!rst || !m_rdy) return 1'b0;
    return bus.flush || ((!m_v || bus.out_ready) && !exp_haz());
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    m_v = 0;
    m_rdy = 0;
  endtask

  task automatic model_step();
    logic adv;
    last_acc = 0;
    if (!rst) return;
    if (!m_rdy) begin m_rdy = 1; return; end
    last_acc = bus.in_valid && exp_in_ready();
    adv = !m_v || bus.out_ready;
    if (bus.flush) begin m_v = 0; m.we = 0; end
    else if (adv && !exp_haz()) begin m_v = bus.in_valid; m = decode_model(bus.in_inst, bus.in_pc); end
    else if (adv) m_v = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] op, f7;
    case ($urandom_range(9))
      0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6f; 3: op = 7'h67; 4: op = 7'h63;
      5: op = 7'h03; 6: op = 7'h23; 7: op = 7'h13; 8: op = 7'h33;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(3))
      0: f7 = 7'h00; 1: f7 = 7'h20; 2: f7 = 7'h01; default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(7)), 5'($urandom_range(7)), 3'($urandom),
            5'($urandom_range(7)), op};
  endfunction

  always @(negedge clk) begin
    chk("out_valid", bus.out_valid, m_v);
    chk("in_ready", bus.in_ready, exp_in_ready());
    chk("rs1_idx", bus.rs1_idx, bus.in_inst[19:15]);
    chk("rs2_idx", bus.rs2_idx, bus.in_inst[24:20]);
    chk("out_inst", bus.out_inst, m.inst);
    chk("out_pc", bus.out_pc, m.pc);
    chk("out_rs1_val", bus.out_rs1_val, m.rs1);
    chk("out_rs2_val", bus.out_rs2_val, m.rs2);
    chk("out_imm", bus.out_imm, m.imm);
    chk("out_rd", bus.out_rd, m.rd);
    chk("out_rd_we", bus.out_rd_we, m.we);
    chk("out_alu_op", bus.out_alu_op, m.alu);
    chk("out_mem_cmd", bus.out_mem_cmd, m.mem);
    chk("out_illegal", bus.out_illegal, m.ill);
    chk("out_muldiv", bus.out_muldiv, m.md);
  end

  initial begin
    model_reset();
    last_acc = 1;
    bus.flush = 0; bus.in_valid = 0; bus.in_inst = 0; bus.in_pc = 0; bus.out_ready = 1;
    bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hdeadbeef;
    repeat (3) cyc();
    rst = 1;
    cyc();

    // Shift-immediates
    bus.in_valid = 1; bus.in_inst = 32'h40525193; bus.in_pc = 32'h100;
    cyc();
    chk("srai_valid", bus.out_valid, 1);
    chk("srai_imm", bus.out_imm, 5);
    chk("srai_alu", bus.out_alu_op, 4'b1110);
    chk("srai_rd_we", bus.out_rd_we, 1);
    bus.in_inst = 32'h00525193;
    cyc();
    chk("srli_alu", bus.out_alu_op, 4'b0110);
    chk("srli_imm", bus.out_imm, 5);

    // Forward priority and x0
    bus.in_inst = 32'h00038433;
    bus.wb_en = 2'b11; bus.wb_rd = {5'd7, 5'd7}; bus.wb_data = {32'h22, 32'h11};
    cyc();
    chk("fwd_prio_rs1", bus.out_rs1_val, 32'h11);
    chk("fwd_x0_rs2", bus.out_rs2_val, 0);
    bus.in_inst = 32'h00000433;
    bus.wb_en = 2'b01; bus.wb_rd = 0; bus.wb_data = {32'h0, 32'h33};
    cyc();
    chk("fwd_x0_never", bus.out_rs1_val, 0);

    // Load-use: LW x5,0(x1) then ADD x6,x5,x1
    bus.wb_en = 0;
    bus.in_inst = 32'h0000A283;
    cyc();
    chk("lw_mem_cmd", bus.out_mem_cmd, 2'b01);
    bus.in_inst = 32'h00128333;
    #1 chk("lu_in_ready_low", bus.in_ready, 0);
    cyc();
    chk("lu_bubble", bus.out_valid, 0);
    bus.wb_en = 2'b01; bus.wb_rd = {5'd0, 5'd5}; bus.wb_data = {32'h0, 32'hCAFE};
    #1 chk("lu_in_ready_high", bus.in_ready, 1);
    cyc();
    chk("lu_issue_valid", bus.out_valid, 1);
    chk("lu_issue_inst", bus.out_inst, 32'h00128333);
    chk("lu_issue_fwd", bus.out_rs1_val, 32'hCAFE);

    // Flush during backpressure with a pending load-use
    bus.wb_en = 0;
    bus.in_inst = 32'h0000A283;
    cyc();
    bus.out_ready = 0; bus.in_inst = 32'h00128333; bus.flush = 1;
    #1 chk("flush_in_ready", bus.in_ready, 1);
    cyc();
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_rd_we", bus.out_rd_we, 0);
    bus.flush = 0; bus.out_ready = 1;

    // MUL x3,x1,x2
    bus.in_inst = 32'h022081B3;
    cyc();
    chk("mul_valid", bus.out_valid, 1);
    chk("mul_illegal", bus.out_illegal, !MEXT);
    chk("mul_rd_we", bus.out_rd_we, MEXT);
    chk("mul_muldiv", bus.out_muldiv, MEXT);

    // Reset mid-stream
    rst = 0;
    model_reset();
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_inst", bus.out_inst, 0);
    chk("rst_rd_we", bus.out_rd_we, 0);
    repeat (2) cyc();
    rst = 1; bus.in_valid = 0;
    #1 chk("rel_in_ready_low", bus.in_ready, 0);
    cyc();
    chk("rel_in_ready_high", bus.in_ready, 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (!(bus.in_valid && !last_acc)) begin
        bus.in_inst = rand_inst();
        bus.in_pc = $urandom;
        bus.in_valid = ($urandom_range(3) != 0);
      end
      bus.flush = ($urandom_range(15) == 0);
      bus.out_ready = ($urandom_range(3) != 0);
      bus.wb_en = 2'($urandom);
      bus.wb_rd = {5'($urandom_range(7)), 5'($urandom_range(7))};
      bus.wb_data = {$urandom, $urandom};
      if ($urandom_range(7) == 0) rf[$urandom_range(31, 1)] = $urandom;
      if (c == 1500) begin
        rst = 0; model_reset(); #1;
        chk("rst2_valid", bus.out_valid, 0);
        cyc();
        rst = 1;
      end
      cyc();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
